// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, error bit indices and parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam int ERR_PAR       = 0;
   localparam int ERR_FRM       = 1;
   localparam int ERR_TMO       = 2;
   localparam int ERR_OVF       = 3;
   localparam int ERR_W         = 4;
   localparam int PS2_DATA_BITS = 8;

   // PS/2 uses odd parity across the data byte and the parity bit together.
   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                          input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_buf_if.sv
// Host-side bundle of the PS/2 receiver: raw lines, control, FIFO read port and error status.
interface ps2_rx_buf_if #(
   parameter int FIFO_DEPTH = 8
);
   import ps2_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                     ps2_clk;
   logic                     ps2_data;
   logic                     rx_en;
   logic                     rd_en;
   logic                     clr_err;
   logic [PS2_DATA_BITS-1:0] dout;
   logic                     empty;
   logic                     full;
   logic [CW-1:0]            count;
   logic [ERR_W-1:0]         err_pulse;
   logic [ERR_W-1:0]         err_sticky;

   modport slave (
      input  ps2_clk, ps2_data, rx_en, rd_en, clr_err,
      output dout, empty, full, count, err_pulse, err_sticky
   );

   modport master (
      output ps2_clk, ps2_data, rx_en, rd_en, clr_err,
      input  dout, empty, full, count, err_pulse, err_sticky
   );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Byte-wide synchronous first-word-fall-through FIFO with occupancy count.
module ps2_sync_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [PS2_DATA_BITS-1:0] wr_data_i,
   input  logic                     rd_en_i,
   output logic [PS2_DATA_BITS-1:0] rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [AW:0]              count_q;
   logic                     do_wr_s, do_rd_s;

   // A full FIFO still accepts a write when the same cycle frees a slot.
   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign do_rd_s   = rd_en_i & ~empty_o;
   assign do_wr_s   = wr_en_i & (~full_o | rd_en_i);
   assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Storage array.
   always_ff @(posedge clk) begin
      if (do_wr_s) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Pointers and occupancy; power-of-2 depth makes pointer wrap free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr_s) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd_s) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_wr_s, do_rd_s})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_buf.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM with timeout, and receive FIFO.
module ps2_rx_buf
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 10000
) (
   input logic          clk,
   input logic          rst,
   ps2_rx_buf_if.slave  bus
);
   localparam int FCW = $clog2(FILT_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);

   logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic filt_q, filt_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic fall_tick_s, fsm_tick_s, tmo_hit_s;
   logic [TCW-1:0] tmo_cnt_q;
   ps2_state_e state_q, state_d;
   logic [2:0] bit_cnt_q;
   logic [PS2_DATA_BITS-1:0] shift_q, push_data_q;
   logic par_q, push_q, push_d, par_err_d, frm_err_d;
   logic [ERR_W-1:0] err_d, err_pulse_q, err_sticky_q;

   // Two-flop synchronisers and the filtered clock level; idle lines are high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q <= 1'b1; clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1; dat_sync_q <= 1'b1;
         filt_q     <= 1'b1; filt_cnt_q <= '0;
      end else begin
         clk_meta_q <= bus.ps2_clk;  clk_sync_q <= clk_meta_q;
         dat_meta_q <= bus.ps2_data; dat_sync_q <= dat_meta_q;
         filt_q     <= filt_d;       filt_cnt_q <= filt_cnt_d;
      end
   end

   // Accept a new clock level only after FILT_LEN consecutive differing samples.
   always_comb begin
      filt_d      = filt_q;
      filt_cnt_d  = '0;
      fall_tick_s = 1'b0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
            filt_d      = clk_sync_q;
            fall_tick_s = ~clk_sync_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end else begin
         filt_cnt_d = '0;
      end
   end

   assign fsm_tick_s = fall_tick_s & bus.rx_en;
   assign tmo_hit_s  = bus.rx_en & (state_q != IDLE) & ~fall_tick_s
                     & (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1));

   // FSM state register and inter-bit timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tmo_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (!bus.rx_en || state_q == IDLE || fall_tick_s || tmo_hit_s) tmo_cnt_q <= '0;
         else                                                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!bus.rx_en || tmo_hit_s) begin
         state_d = IDLE;
      end else if (fsm_tick_s) begin
         case (state_q)
            IDLE:    state_d = dat_sync_q ? IDLE : DATA;
            DATA:    state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Frame completion outputs; a bad stop bit masks a parity error.
   always_comb begin
      push_d    = 1'b0;
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
      if (fsm_tick_s && state_q == STOP) begin
         frm_err_d = ~dat_sync_q;
         par_err_d = dat_sync_q & ~odd_parity_ok(shift_q, par_q);
         push_d    = dat_sync_q &  odd_parity_ok(shift_q, par_q);
      end else begin
         push_d = 1'b0;
      end
   end

   // Frame datapath: LSB-first shift register, bit counter, parity capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
      end else if (fsm_tick_s) begin
         case (state_q)
            IDLE:    bit_cnt_q <= '0;
            DATA: begin
               shift_q   <= {dat_sync_q, shift_q[PS2_DATA_BITS-1:1]};
               bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            PARITY:  par_q <= dat_sync_q;
            default: bit_cnt_q <= bit_cnt_q;
         endcase
      end
   end

   assign err_d[ERR_PAR] = par_err_d;
   assign err_d[ERR_FRM] = frm_err_d;
   assign err_d[ERR_TMO] = tmo_hit_s;
   assign err_d[ERR_OVF] = push_q & bus.full & ~bus.rd_en;

   // Registered push request and error reporting; a new pulse beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_q       <= 1'b0;
         push_data_q  <= '0;
         err_pulse_q  <= '0;
         err_sticky_q <= '0;
      end else begin
         push_q       <= push_d;
         push_data_q  <= shift_q;
         err_pulse_q  <= err_d;
         err_sticky_q <= (bus.clr_err ? 4'b0000 : err_sticky_q) | err_d;
      end
   end

   assign bus.err_pulse  = err_pulse_q;
   assign bus.err_sticky = err_sticky_q;

   ps2_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push_q),
      .wr_data_i (push_data_q),
      .rd_en_i   (bus.rd_en),
      .rd_data_o (bus.dout),
      .empty_o   (bus.empty),
      .full_o    (bus.full),
      .count_o   (bus.count)
   );

endmodule

// File: tb/tb_ps2_rx_buf.sv
// Directed self-checking bench for ps2_rx_buf with a scaled-down PS/2 bit period and timeout.
module tb_ps2_rx_buf;

   localparam int HALF = 20;
   localparam int TMO  = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pcnt [4] = '{0, 0, 0, 0};
   int   snap [4];

   ps2_rx_buf_if #(.FIFO_DEPTH(8)) bus ();

   ps2_rx_buf #(.FILT_LEN(4), .FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Count high cycles of each err_pulse bit.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) if (bus.err_pulse[i]) pcnt[i] = pcnt[i] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic flip, input logic stp);
      return {stp, (~^d) ^ flip, d, 1'b0};
   endfunction

   task automatic send(input logic [10:0] bits, input int nbits, input logic glitch);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = bits[i];
         cyc(HALF / 2);
         if (glitch) begin
            bus.ps2_clk = 1'b0;
            cyc(1);
            bus.ps2_clk = 1'b1;
            cyc(HALF / 2 - 1);
         end else begin
            cyc(HALF / 2);
         end
         bus.ps2_clk = 1'b0;
         cyc(HALF);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      cyc(HALF);
   endtask

   task automatic take_snap();
      for (int i = 0; i < 4; i++) snap[i] = pcnt[i];
   endtask

   task automatic check_pulses(input string tag, input logic [3:0] exp);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_pulse%0d", tag, i), pcnt[i] - snap[i], {31'd0, exp[i]});
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check(tag, {24'd0, bus.dout}, {24'd0, exp});
      bus.rd_en = 1'b1;
      cyc(1);
      bus.rd_en = 1'b0;
   endtask

   task automatic clear_err();
      bus.clr_err = 1'b1;
      cyc(1);
      bus.clr_err = 1'b0;
   endtask

   initial begin
      bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.rx_en = 1'b1;
      bus.rd_en = 1'b0;   bus.clr_err = 1'b0;
      cyc(3);
      check("rst_dout",   {24'd0, bus.dout},      32'h00);
      check("rst_empty",  {31'd0, bus.empty},     32'd1);
      check("rst_full",   {31'd0, bus.full},      32'd0);
      check("rst_count",  {28'd0, bus.count},     32'd0);
      check("rst_pulse",  {28'd0, bus.err_pulse}, 32'd0);
      check("rst_sticky", {28'd0, bus.err_sticky},32'd0);
      rst = 1'b0;
      cyc(5);

      // Single valid byte.
      take_snap();
      send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
      check("b1c_count", {28'd0, bus.count}, 32'd1);
      check_pulses("b1c", 4'b0000);
      pop_check("b1c_dout", 8'h1C);
      check("b1c_empty", {31'd0, bus.empty}, 32'd1);

      // Nine bytes into an 8-deep FIFO.
      take_snap();
      for (int b = 1; b <= 9; b++) send(mk(8'(b), 1'b0, 1'b1), 11, 1'b0);
      check("ovf_count", {28'd0, bus.count}, 32'd8);
      check("ovf_full",  {31'd0, bus.full},  32'd1);
      check_pulses("ovf", 4'b1000);
      check("ovf_sticky", {28'd0, bus.err_sticky}, 32'h8);
      for (int b = 1; b <= 8; b++) pop_check($sformatf("ovf_rd%0d", b), 8'(b));
      check("ovf_empty", {31'd0, bus.empty}, 32'd1);
      check("ovf_dout0", {24'd0, bus.dout}, 32'h00);
      clear_err();
      check("ovf_clr", {28'd0, bus.err_sticky}, 32'd0);

      // Parity error.
      take_snap();
      send(mk(8'h5A, 1'b1, 1'b1), 11, 1'b0);
      check("par_count", {28'd0, bus.count}, 32'd0);
      check_pulses("par", 4'b0001);
      check("par_sticky", {28'd0, bus.err_sticky}, 32'h1);
      clear_err();
      check("par_clr", {28'd0, bus.err_sticky}, 32'd0);

      // Framing error, with bad parity too so frame must win.
      take_snap();
      send(mk(8'h5A, 1'b1, 1'b0), 11, 1'b0);
      check("frm_count", {28'd0, bus.count}, 32'd0);
      check_pulses("frm", 4'b0010);
      check("frm_sticky", {28'd0, bus.err_sticky}, 32'h2);
      clear_err();

      // Partial frame then timeout; next frame must be clean.
      take_snap();
      send(mk(8'h33, 1'b0, 1'b1), 4, 1'b0);
      cyc(TMO + 50);
      check_pulses("tmo", 4'b0100);
      check("tmo_sticky", {28'd0, bus.err_sticky}, 32'h4);
      clear_err();
      take_snap();
      send(mk(8'h33, 1'b0, 1'b1), 11, 1'b0);
      check("aft_count", {28'd0, bus.count}, 32'd1);
      check_pulses("aft", 4'b0000);
      pop_check("aft_dout", 8'h33);

      // Short clock glitches are filtered out.
      take_snap();
      send(mk(8'hA5, 1'b0, 1'b1), 11, 1'b1);
      check("glt_count", {28'd0, bus.count}, 32'd1);
      check_pulses("glt", 4'b0000);
      pop_check("glt_dout", 8'hA5);

      // Disabling mid-frame discards it silently.
      take_snap();
      send(mk(8'hA5, 1'b0, 1'b1), 5, 1'b0);
      bus.rx_en = 1'b0;
      cyc(10);
      bus.rx_en = 1'b1;
      cyc(10);
      send(mk(8'h77, 1'b0, 1'b1), 11, 1'b0);
      check("ren_count", {28'd0, bus.count}, 32'd1);
      check_pulses("ren", 4'b0000);
      check("ren_sticky", {28'd0, bus.err_sticky}, 32'd0);
      pop_check("ren_dout", 8'h77);

      // Asynchronous reset mid-frame with three bytes buffered.
      send(mk(8'h11, 1'b0, 1'b1), 11, 1'b0);
      send(mk(8'h22, 1'b0, 1'b1), 11, 1'b0);
      send(mk(8'h33, 1'b0, 1'b1), 11, 1'b0);
      check("ar_pre_count", {28'd0, bus.count}, 32'd3);
      send(mk(8'h44, 1'b0, 1'b1), 4, 1'b0);
      #3 rst = 1'b1;
      #1;
      check("ar_count", {28'd0, bus.count}, 32'd0);
      check("ar_empty", {31'd0, bus.empty}, 32'd1);
      check("ar_dout",  {24'd0, bus.dout},  32'h00);
      cyc(3);
      rst = 1'b0;
      cyc(5);
      take_snap();
      send(mk(8'h10, 1'b0, 1'b1), 11, 1'b0);
      check("ar_post_count", {28'd0, bus.count}, 32'd1);
      check("ar_post_dout",  {24'd0, bus.dout},  32'h10);
      check_pulses("ar_post", 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
